// File: rtl/hazard_scoreboard_if.sv
// Decode-stage handshake between the ID stage (master) and the hazard scoreboard (slave).
// Carries the ID operand/destination fields plus the stall and forwarding-select responses.
interface hazard_scoreboard_if #(
  parameter int ADDR_W  = 5,
  parameter int MAX_LAT = 3
) ();

  localparam int SEL_W = $clog2(MAX_LAT + 1);

  logic              id_valid;
  logic              id_kill;
  logic [ADDR_W-1:0] id_rs;
  logic              id_rs_used;
  logic [ADDR_W-1:0] id_rt;
  logic              id_rt_used;
  logic [ADDR_W-1:0] id_rd;
  logic              id_rd_wen;
  logic              id_is_load;
  logic              stall;
  logic [SEL_W-1:0]  fwd_rs_sel;
  logic [SEL_W-1:0]  fwd_rt_sel;

  modport master (
    output id_valid, id_kill, id_rs, id_rs_used, id_rt, id_rt_used,
           id_rd, id_rd_wen, id_is_load,
    input  stall, fwd_rs_sel, fwd_rt_sel
  );

  modport slave (
    input  id_valid, id_kill, id_rs, id_rs_used, id_rt, id_rt_used,
           id_rd, id_rd_wen, id_is_load,
    output stall, fwd_rs_sel, fwd_rt_sel
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard producing ID stall, forwarding selects, busy vector and perf counters.
// Define HAZ_FWD_EN to build the forwarding network (stalls limited to load-use hazards).
module hazard_scoreboard #(
  parameter int ADDR_W  = 5,
  parameter int MAX_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  hazard_scoreboard_if.slave     id,
  input  logic                   cnt_clr,
  output logic [2**ADDR_W-1:0]   busy_vec,
  output logic [CNT_W-1:0]       issue_cnt,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam int SEL_W    = $clog2(MAX_LAT + 1);

  localparam logic [SEL_W-1:0] LAT     = SEL_W'(MAX_LAT);
  localparam logic [SEL_W-1:0] CNT_ONE = SEL_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

  // Scoreboard state: remaining busy cycles per architectural register.
  logic [NUM_REGS-1:0][SEL_W-1:0] cnt_q;
  logic [NUM_REGS-1:0][SEL_W-1:0] cnt_d;

  logic [SEL_W-1:0] rs_cnt;
  logic [SEL_W-1:0] rt_cnt;
  logic             rs_haz;
  logic             rt_haz;
  logic             issue;
  logic             alloc;

  // Decode always looks at the pre-update state, so rd == rs sees the older producer.
  assign rs_cnt = cnt_q[id.id_rs];
  assign rt_cnt = cnt_q[id.id_rt];
  assign rs_haz = id.id_rs_used && (rs_cnt != '0);
  assign rt_haz = id.id_rt_used && (rt_cnt != '0);

  assign issue  = id.id_valid && !id.id_kill && !id.stall;
  assign alloc  = issue && id.id_rd_wen && (id.id_rd != '0);

`ifdef HAZ_FWD_EN

  localparam int               SEL_W1 = SEL_W + 1;
  localparam logic [SEL_W:0]   LAT_P1 = SEL_W1'(MAX_LAT + 1);

  logic [NUM_REGS-1:0] ld_q;
  logic [NUM_REGS-1:0] ld_d;
  logic                rs_lu;
  logic                rt_lu;

  // Only a load still in its first cycle after issue cannot be forwarded yet.
  assign rs_lu = rs_haz && ld_q[id.id_rs] && (rs_cnt == LAT);
  assign rt_lu = rt_haz && ld_q[id.id_rt] && (rt_cnt == LAT);

  assign id.stall = id.id_valid && !id.id_kill && (rs_lu || rt_lu);

  // Stage distance from ID: a fresh entry (cnt == MAX_LAT) sits one stage ahead.
  function automatic logic [SEL_W-1:0] fwd_sel(input logic haz, input logic [SEL_W-1:0] c);
    logic [SEL_W:0] dist;
    dist = LAT_P1 - {1'b0, c};
    return haz ? dist[SEL_W-1:0] : '0;
  endfunction

  assign id.fwd_rs_sel = fwd_sel(rs_haz, rs_cnt);
  assign id.fwd_rt_sel = fwd_sel(rt_haz, rt_cnt);

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      ld_d[r] = ld_q[r] && (cnt_q[r] > CNT_ONE);
    end
    if (alloc) begin
      ld_d[id.id_rd] = id.id_is_load;
    end
    ld_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_q <= '0;
    end else begin
      ld_q <= ld_d;
    end
  end

`else

  logic unused_is_load;

  assign unused_is_load = id.id_is_load;

  // Without forwarding any busy source waits for its producer to retire.
  assign id.stall      = id.id_valid && !id.id_kill && (rs_haz || rt_haz);
  assign id.fwd_rs_sel = '0;
  assign id.fwd_rt_sel = '0;

`endif

  // NOTE: every variable written here gets a value before any condition, so no latch is inferred.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_ONE : '0;
    end
    if (alloc) begin
      cnt_d[id.id_rd] = LAT;
    end
    cnt_d[0] = '0;
  end

  // NOTE: the scoreboard is a flop array, not a RAM, and is reset in full so no stale hazard survives reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_vec[r] = (cnt_q[r] != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_cnt <= '0;
    end else if (cnt_clr) begin
      issue_cnt <= '0;
    end else if (issue && (issue_cnt != CNT_MAX)) begin
      issue_cnt <= issue_cnt + CNT_INC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (id.stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_INC;
    end
  end

endmodule
